// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle logical shifter, one bit position per clock.
// A request is accepted in IDLE on start. The word then shifts once per cycle
// in SHIFT, and done pulses for the single FIN cycle.
// busy and done are registered from the next-state decode, so they line up
// exactly with the state register.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sh_dir,
    input  logic [AMT_W-1:0] sh_amt,
    input  logic [WIDTH-1:0] d_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] count, count_nxt;
    logic             dir, dir_nxt;
    logic [WIDTH-1:0] data_nxt;

    // The largest shift amount must stay inside the word.
    if ((2 ** AMT_W) > WIDTH) begin : g_bad_amt_w
        $error("seq_shifter: 2**AMT_W must not exceed WIDTH");
    end

    // Next-state and datapath decode. A zero amount goes straight to FIN.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        dir_nxt   = dir;
        data_nxt  = d_out;
        case (state)
            IDLE: begin
                if (start) begin
                    data_nxt  = d_in;
                    count_nxt = sh_amt;
                    dir_nxt   = sh_dir;
                    state_nxt = (sh_amt != '0) ? SHIFT : FIN;
                end
            end
            SHIFT: begin
                data_nxt  = dir ? {1'b0, d_out[WIDTH-1:1]} : {d_out[WIDTH-2:0], 1'b0};
                count_nxt = count - AMT_W'(1);
                if (count == AMT_W'(1)) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, working register and registered status flags. Reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            dir   <= 1'b0;
            d_out <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            dir   <= dir_nxt;
            d_out <= data_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == FIN);
        end
    end

endmodule
